// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with 16-byte lines.
// Read hits complete combinationally. A read miss holds the memory address for
// MEM_LATENCY cycles and then captures the whole line. Every store produces one
// memWrite cycle. Retired loads and read misses are counted; both counters saturate.
module data_cache_controller #(
  parameter int LINES       = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic         CLk,
  input  logic         reset_n,
  input  logic [31:0]  cpuAddress,
  input  logic [31:0]  cpuWriteData,
  input  logic         cpuRead,
  input  logic         cpuWrite,
  output logic [31:0]  cpuReadData,
  output logic         stall,
  output logic [31:0]  memAddress,
  output logic [31:0]  memInputData,
  output logic         memWrite,
  input  logic [127:0] memData,
  output logic [15:0]  readCount,
  output logic [15:0]  missCount
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LINES-1:0]   r_valid;
  logic [23:0]        r_tag  [LINES];
  logic [127:0]       r_line [LINES];
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic               r_mem_write;
  logic [15:0]        r_read_cnt;
  logic [15:0]        r_miss_cnt;

  logic [3:0]         w_idx;
  logic [1:0]         w_word;
  logic               w_hit;
  logic [31:0]        w_cached_word;
  logic               w_stall;
  logic [31:0]        w_rdata;
  logic               w_read_hit;
  logic               w_start_write;
  logic               w_start_refill;
  logic               w_refill_done;
  logic               w_unused_addr_lsb;

  // Byte-offset bits within a word are not needed: all accesses are word accesses.
  assign w_unused_addr_lsb = ^cpuAddress[1:0];

  assign w_idx         = cpuAddress[7:4];
  assign w_word        = cpuAddress[3:2];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == cpuAddress[31:8]);
  assign w_cached_word = r_line[w_idx][{w_word, 5'd0} +: 32];

  // Outputs that must read as zero for the whole time reset is held.
  assign stall        = reset_n & w_stall;
  assign cpuReadData  = reset_n ? w_rdata : 32'd0;
  assign memAddress   = r_mem_addr;
  assign memInputData = r_mem_wdata;
  assign memWrite     = r_mem_write;
  assign readCount    = r_read_cnt;
  assign missCount    = r_miss_cnt;

  // State register.
  always_ff @(posedge CLk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state and per-cycle control; a store wins over a load in the same cycle.
  always_comb begin
    w_next_state   = r_state;
    w_stall        = 1'b0;
    w_rdata        = 32'd0;
    w_read_hit     = 1'b0;
    w_start_write  = 1'b0;
    w_start_refill = 1'b0;
    w_refill_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpuWrite) begin
          w_stall       = 1'b1;
          w_start_write = 1'b1;
          w_next_state  = S_WRITE;
        end else if (cpuRead) begin
          if (w_hit) begin
            w_rdata    = w_cached_word;
            w_read_hit = 1'b1;
          end else begin
            w_stall        = 1'b1;
            w_start_refill = 1'b1;
            w_next_state   = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        w_stall = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_refill_done = 1'b1;
          w_next_state  = S_IDLE;
        end
      end
      S_WRITE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Memory interface, refill timer, valid bits and saturating counters.
  always_ff @(posedge CLk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_write <= 1'b0;
      r_cnt       <= '0;
      r_valid     <= '0;
      r_read_cnt  <= 16'd0;
      r_miss_cnt  <= 16'd0;
    end else begin
      r_mem_write <= w_start_write;
      if (w_start_write) begin
        r_mem_addr  <= cpuAddress;
        r_mem_wdata <= cpuWriteData;
      end
      if (w_start_refill) begin
        r_mem_addr <= {cpuAddress[31:4], 4'b0000};
        r_cnt      <= '0;
        if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
      end else if (r_state == S_REFILL) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_refill_done) r_valid[w_idx] <= 1'b1;
      if (w_read_hit && (r_read_cnt != 16'hFFFF)) r_read_cnt <= r_read_cnt + 16'd1;
    end
  end

  // Tag and line storage; contents only matter where the valid bit is set.
  always_ff @(posedge CLk) begin
    if (w_refill_done) begin
      r_line[w_idx] <= memData;
      r_tag[w_idx]  <= cpuAddress[31:8];
    end else if (w_start_write && w_hit) begin
      r_line[w_idx][{w_word, 5'd0} +: 32] <= cpuWriteData;
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Bench for data_cache_controller: directed scenarios plus random load/store traffic,
// checked against a line-presence model and a shadow image of memory contents.
module tb_data_cache_controller;

  logic         CLk = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  cpuAddress = 32'd0;
  logic [31:0]  cpuWriteData = 32'd0;
  logic         cpuRead = 1'b0;
  logic         cpuWrite = 1'b0;
  logic [31:0]  cpuReadData;
  logic         stall;
  logic [31:0]  memAddress;
  logic [31:0]  memInputData;
  logic         memWrite;
  logic [127:0] memData = 128'd0;
  logic [15:0]  readCount;
  logic [15:0]  missCount;

  int n_cmp = 0;
  int n_fail = 0;

  data_cache_controller dut (
    .CLk(CLk), .reset_n(reset_n),
    .cpuAddress(cpuAddress), .cpuWriteData(cpuWriteData),
    .cpuRead(cpuRead), .cpuWrite(cpuWrite),
    .cpuReadData(cpuReadData), .stall(stall),
    .memAddress(memAddress), .memInputData(memInputData), .memWrite(memWrite),
    .memData(memData), .readCount(readCount), .missCount(missCount)
  );

  always #5 CLk = ~CLk;

  // Memory environment (4 KiB, aliased): writes on negedge, data refreshed every 4 negedges.
  logic [31:0] mem [1024];
  int neg_cnt = 0;
  always @(negedge CLk) begin
    logic [9:0] base;
    if (memWrite) mem[memAddress[11:2]] = memInputData;
    neg_cnt++;
    if (neg_cnt % 4 == 0) begin
      base = {memAddress[11:4], 2'b00};
      memData = {mem[base + 10'd3], mem[base + 10'd2], mem[base + 10'd1], mem[base]};
    end
  end

  // Reference model: expected memory image, which lines are present, counters.
  logic [31:0] exp_mem [1024];
  bit          m_valid [16];
  logic [23:0] m_tag [16];
  int          m_reads;
  int          m_misses;

  function automatic logic [31:0] init_word(int w);
    logic [31:0] b;
    b = w * 4;
    return {b[7:0] + 8'd3, b[7:0] + 8'd2, b[7:0] + 8'd1, b[7:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    m_reads = 0;
    m_misses = 0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    bit          hit;
    int          exp_stalls, stalls;
    logic [31:0] exp_data, got;
    hit = m_valid[addr[7:4]] && (m_tag[addr[7:4]] == addr[31:8]);
    exp_stalls = hit ? 0 : 5;
    exp_data = exp_mem[addr[11:2]];
    cpuAddress = addr; cpuRead = 1'b1; cpuWrite = 1'b0;
    stalls = 0;
    forever begin
      @(negedge CLk);
      if (!stall) break;
      stalls++;
      if (stalls > 20) break;
      @(posedge CLk); #1;
    end
    got = cpuReadData;
    @(posedge CLk); #1;
    cpuRead = 1'b0;
    if (!hit) begin
      m_valid[addr[7:4]] = 1;
      m_tag[addr[7:4]] = addr[31:8];
      if (m_misses < 65535) m_misses++;
    end
    if (m_reads < 65535) m_reads++;
    n_cmp++;
    if (stalls !== exp_stalls) begin
      n_fail++; $display("FAIL read_stalls addr=%h got=%0d exp=%0d", addr, stalls, exp_stalls);
    end
    n_cmp++;
    if (got !== exp_data) begin
      n_fail++; $display("FAIL read_data addr=%h got=%h exp=%h", addr, got, exp_data);
    end
    n_cmp++;
    if (readCount !== 16'(m_reads) || missCount !== 16'(m_misses)) begin
      n_fail++; $display("FAIL read_counts addr=%h got=%0d/%0d exp=%0d/%0d",
                         addr, readCount, missCount, m_reads, m_misses);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit also_read);
    logic s0, s1, mw;
    logic [31:0] ma, md;
    cpuAddress = addr; cpuWriteData = data; cpuWrite = 1'b1; cpuRead = also_read;
    @(negedge CLk); s0 = stall;
    @(posedge CLk); #1;
    @(negedge CLk); s1 = stall; mw = memWrite; ma = memAddress; md = memInputData;
    @(posedge CLk); #1;
    cpuWrite = 1'b0; cpuRead = 1'b0;
    exp_mem[addr[11:2]] = data;
    n_cmp++;
    if (s0 !== 1'b1 || s1 !== 1'b0) begin
      n_fail++; $display("FAIL write_stall addr=%h got=%b%b exp=10", addr, s0, s1);
    end
    n_cmp++;
    if (mw !== 1'b1 || ma !== addr || md !== data) begin
      n_fail++; $display("FAIL write_mem got we=%b a=%h d=%h exp we=1 a=%h d=%h", mw, ma, md, addr, data);
    end
    n_cmp++;
    if (memWrite !== 1'b0) begin
      n_fail++; $display("FAIL write_pulse_end got=%b exp=0", memWrite);
    end
    n_cmp++;
    if (readCount !== 16'(m_reads) || missCount !== 16'(m_misses)) begin
      n_fail++; $display("FAIL write_counts got=%0d/%0d exp=%0d/%0d", readCount, missCount, m_reads, m_misses);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpuAddress = 32'h40; cpuRead = 1'b1;
    #23;
    n_cmp++;
    if (stall !== 1'b0 || cpuReadData !== 32'd0 || memWrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs got stall=%b rd=%h we=%b exp 0/0/0", stall, cpuReadData, memWrite);
    end
    n_cmp++;
    if (memAddress !== 32'd0 || memInputData !== 32'd0 || readCount !== 16'd0 || missCount !== 16'd0) begin
      n_fail++; $display("FAIL reset_regs got a=%h d=%h rc=%0d mc=%0d exp all 0", memAddress, memInputData, readCount, missCount);
    end
    cpuRead = 1'b0;
    @(posedge CLk); #1;
    reset_n = 1'b1;
    model_reset();
    @(posedge CLk); #1;
  endtask

  task automatic test_directed();
    do_read(32'h40);
    do_read(32'h44);
    do_write(32'h48, 32'hDEADBEEF, 0);
    do_read(32'h48);
    do_write(32'h200, 32'h12345678, 0);
    do_read(32'h200);
    do_read(32'h40);
    do_read(32'h140);
    do_read(32'h40);
    do_read(32'h4F);
  endtask

  task automatic test_both_high();
    do_write(32'h44, 32'hCAFEF00D, 1);
    do_read(32'h44);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 200; i++) begin
      a = 32'($urandom_range(0, 32'h3FF));
      if ($urandom_range(0, 9) < 3) do_write(a, $urandom, $urandom_range(0, 1) == 1);
      else do_read(a);
    end
  endtask

  task automatic test_reset_abort();
    // Reset while the store's memWrite cycle is active.
    cpuAddress = 32'h3C; cpuWriteData = 32'h55AA55AA; cpuWrite = 1'b1;
    @(posedge CLk); #1;
    n_cmp++;
    if (memWrite !== 1'b1) begin
      n_fail++; $display("FAIL abort_write_pre got=%b exp=1", memWrite);
    end
    reset_n = 1'b0; #1;
    n_cmp++;
    if (memWrite !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL abort_write got we=%b stall=%b exp 0/0", memWrite, stall);
    end
    cpuWrite = 1'b0;
    @(posedge CLk); #1;
    reset_n = 1'b1;
    model_reset();
    @(posedge CLk); #1;
    // Reset during a refill, three cycles into the memory wait.
    do_read(32'h44);
    cpuAddress = 32'h800; cpuRead = 1'b1;
    repeat (3) begin @(posedge CLk); #1; end
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL abort_refill_pre got stall=%b exp=1", stall);
    end
    reset_n = 1'b0; #1;
    n_cmp++;
    if (stall !== 1'b0 || memWrite !== 1'b0 || readCount !== 16'd0 || missCount !== 16'd0 || cpuReadData !== 32'd0) begin
      n_fail++; $display("FAIL abort_refill got stall=%b we=%b rc=%0d mc=%0d rd=%h exp 0",
                         stall, memWrite, readCount, missCount, cpuReadData);
    end
    @(posedge CLk); #1;
    reset_n = 1'b1;
    model_reset();
    do_read(32'h800);
    do_read(32'h44);
  endtask

  initial begin
    for (int w = 0; w < 1024; w++) begin
      mem[w] = init_word(w);
      exp_mem[w] = init_word(w);
    end
    model_reset();
    test_reset();
    test_directed();
    test_both_high();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
